// File: rtl/ls_pkg.sv
// Shared encodings and the alignment rule for the load/store unit.
package ls_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LDONE = 3'd2,
    WR    = 3'd3,
    MERGE = 3'd4,
    ERR   = 3'd5
  } ls_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Big-endian lane extraction/extension for loads and lane merge for sub-word stores.
module ls_lane_align
  import ls_pkg::*;
(
  input  logic [31:0] rdata_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Offset 0 is the most significant byte of the word.
  always_comb begin
    byte_lane   = 8'd0;
    half_lane   = 16'd0;
    load_value  = 32'd0;
    merged_word = rdata_word;
    case (offset)
      2'd0:    byte_lane = rdata_word[31:24];
      2'd1:    byte_lane = rdata_word[23:16];
      2'd2:    byte_lane = rdata_word[15:8];
      2'd3:    byte_lane = rdata_word[7:0];
      default: byte_lane = 8'd0;
    endcase
    if (offset[1]) begin
      half_lane = rdata_word[15:0];
    end else begin
      half_lane = rdata_word[31:16];
    end
    case (size)
      SZ_BYTE: begin
        load_value = zero_ext ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        case (offset)
          2'd0:    merged_word[31:24] = store_data[7:0];
          2'd1:    merged_word[23:16] = store_data[7:0];
          2'd2:    merged_word[15:8]  = store_data[7:0];
          2'd3:    merged_word[7:0]   = store_data[7:0];
          default: merged_word = rdata_word;
        endcase
      end
      SZ_HALF: begin
        load_value = zero_ext ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
        if (offset[1]) begin
          merged_word[15:0] = store_data[15:0];
        end else begin
          merged_word[31:16] = store_data[15:0];
        end
      end
      SZ_WORD: begin
        load_value  = rdata_word;
        merged_word = store_data;
      end
      default: begin
        load_value  = 32'd0;
        merged_word = rdata_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-organised data memory.
// Sub-word stores run a read-modify-write; one request in flight at a time.
module load_store_unit
  import ls_pkg::*;
#(
  parameter int DM = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          misaligned,
  output logic [DM-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [31:0]   mem_rdata
);

  ls_state_e     state_q, state_d;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic          unsigned_q, unsigned_d;
  logic [DM+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          accept_s;
  logic [31:0]   load_value_s;
  logic [31:0]   merged_word_s;
  logic          unused_addr_s;

  assign unused_addr_s = ^req_addr[31:DM+2];
  assign accept_s      = req_valid && req_ready;

  ls_lane_align u_align (
    .rdata_word  (mem_rdata),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .zero_ext    (unsigned_q),
    .store_data  (wdata_q),
    .load_value  (load_value_s),
    .merged_word (merged_word_s)
  );

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr[DM+1:0];
          wdata_d    = req_wdata;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d = ERR;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD:      state_d = write_q ? MERGE : LDONE;
      LDONE:   state_d = IDLE;
      WR:      state_d = IDLE;
      MERGE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Strobes are gated by reset so an aborted RMW never reaches memory.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    misaligned = 1'b0;
    mem_addr   = addr_q[DM+1:2];
    mem_wdata  = 32'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: req_ready = 1'b1;
        RD:   mem_read  = 1'b1;
        LDONE: begin
          resp_valid = 1'b1;
          resp_rdata = load_value_s;
        end
        WR: begin
          mem_write  = 1'b1;
          mem_wdata  = wdata_q;
          resp_valid = 1'b1;
        end
        MERGE: begin
          mem_write  = 1'b1;
          mem_wdata  = merged_word_s;
          resp_valid = 1'b1;
        end
        ERR: begin
          resp_valid = 1'b1;
          misaligned = 1'b1;
        end
        default: req_ready = 1'b0;
      endcase
    end else begin
      req_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  localparam int DM = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          misaligned;
  logic [DM-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_rdata;

  logic [31:0] mem [0:(2**DM)-1];

  int passed = 0;
  int total  = 0;
  int both_strobes = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_mwdata;
  } vec_t;

  vec_t vecs [0:18];

  int          got_lat;
  logic [31:0] got_rdata;
  logic        got_mis;
  logic        saw_rd;
  logic        saw_wr;
  logic [31:0] got_mwdata;
  logic        addr_bad;

  always #5 clk = ~clk;

  load_store_unit #(.DM(DM)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misaligned   (misaligned),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) both_strobes = both_strobes + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) begin
      passed = passed + 1;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic wr, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_mis, input int exp_lat,
                               input logic exp_rd, input logic exp_wr, input logic [31:0] exp_mwdata);
    vec_t v;
    v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_mis = exp_mis; v.exp_lat = exp_lat;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_mwdata = exp_mwdata;
    return v;
  endfunction

  task automatic run_req(input vec_t v);
    bit done;
    @(negedge clk);
    req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    check("ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5;
    req_size = 2'd0; req_unsigned = ~v.uns;
    got_lat = 0; got_rdata = 32'd0; got_mis = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0;
    got_mwdata = 32'd0; addr_bad = 1'b0; done = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (!done) begin
        @(negedge clk);
        if (mem_read) saw_rd = 1'b1;
        if (mem_write) begin
          saw_wr = 1'b1;
          got_mwdata = mem_wdata;
        end
        if ((mem_read || mem_write) && (mem_addr != v.addr[DM+1:2])) addr_bad = 1'b1;
        if (resp_valid) begin
          got_lat = c; got_rdata = resp_rdata; got_mis = misaligned; done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    vec_t v;
    int accept_cyc;
    int resp_cnt;
    int resp_first;
    int resp_second;
    int ready_busy;
    bit wr_seen;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    vecs[0]  = mkv(1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    vecs[1]  = mkv(1'b0, 2'd0, 1'b0, 32'h0000_0009, 32'h0,         32'hFFFF_FFAD, 1'b0, 2, 1'b1, 1'b0, 32'h0);
    vecs[2]  = mkv(1'b0, 2'd0, 1'b1, 32'h0000_0009, 32'h0,         32'h0000_00AD, 1'b0, 2, 1'b1, 1'b0, 32'h0);
    vecs[3]  = mkv(1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1'b1, 1'b0, 32'h0);
    vecs[4]  = mkv(1'b1, 2'd1, 1'b0, 32'h0000_000A, 32'h0000_1234, 32'h0, 1'b0, 2, 1'b1, 1'b1, 32'hDEAD_1234);
    vecs[5]  = mkv(1'b0, 2'd1, 1'b1, 32'h0000_000A, 32'h0,         32'h0000_1234, 1'b0, 2, 1'b1, 1'b0, 32'h0);
    vecs[6]  = mkv(1'b0, 2'd1, 1'b0, 32'h0000_0008, 32'h0,         32'hFFFF_DEAD, 1'b0, 2, 1'b1, 1'b0, 32'h0);
    vecs[7]  = mkv(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0,         32'h0, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    vecs[8]  = mkv(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,         32'h0, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    vecs[9]  = mkv(1'b0, 2'd1, 1'b0, 32'h0000_0009, 32'h0,         32'h0, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    vecs[10] = mkv(1'b1, 2'd2, 1'b0, 32'h0000_000A, 32'h1111_1111, 32'h0, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    vecs[11] = mkv(1'b1, 2'd0, 1'b0, 32'h0000_000B, 32'hFFFF_FF55, 32'h0, 1'b0, 2, 1'b1, 1'b1, 32'hDEAD_1255);
    vecs[12] = mkv(1'b0, 2'd0, 1'b0, 32'h0000_000B, 32'h0,         32'h0000_0055, 1'b0, 2, 1'b1, 1'b0, 32'h0);
    vecs[13] = mkv(1'b1, 2'd2, 1'b0, 32'h0000_0004, 32'h1234_5678, 32'h0, 1'b0, 1, 1'b0, 1'b1, 32'h1234_5678);
    vecs[14] = mkv(1'b1, 2'd0, 1'b0, 32'h0000_0004, 32'h0000_0080, 32'h0, 1'b0, 2, 1'b1, 1'b1, 32'h8034_5678);
    vecs[15] = mkv(1'b0, 2'd0, 1'b0, 32'h0000_0004, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 1'b1, 1'b0, 32'h0);
    vecs[16] = mkv(1'b0, 2'd1, 1'b1, 32'h0000_0004, 32'h0,         32'h0000_8034, 1'b0, 2, 1'b1, 1'b0, 32'h0);
    vecs[17] = mkv(1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0,         32'h0000_5678, 1'b0, 2, 1'b1, 1'b0, 32'h0);
    vecs[18] = mkv(1'b0, 2'd2, 1'b0, 32'hFFFF_FE08, 32'h0,         32'hDEAD_1255, 1'b0, 2, 1'b1, 1'b0, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_misaligned", {31'd0, misaligned}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i <= 18; i++) begin
      v = vecs[i];
      run_req(v);
      check($sformatf("v%0d_latency", i), got_lat, v.exp_lat);
      check($sformatf("v%0d_rdata", i), got_rdata, v.exp_rdata);
      check($sformatf("v%0d_misaligned", i), {31'd0, got_mis}, {31'd0, v.exp_mis});
      check($sformatf("v%0d_mem_read_seen", i), {31'd0, saw_rd}, {31'd0, v.exp_rd});
      check($sformatf("v%0d_mem_write_seen", i), {31'd0, saw_wr}, {31'd0, v.exp_wr});
      check($sformatf("v%0d_mem_addr_ok", i), {31'd0, addr_bad}, 32'd0);
      if (v.exp_wr) check($sformatf("v%0d_mem_wdata", i), got_mwdata, v.exp_mwdata);
    end

    // sb interrupted by reset during RD: no write, no response
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0000_000B; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1 req_valid = 1'b0; reset = 1'b1;
    wr_seen = 1'b0; resp_cnt = 0;
    @(negedge clk);
    if (mem_write) wr_seen = 1'b1;
    if (resp_valid) resp_cnt = resp_cnt + 1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after_reset", {31'd0, req_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      if (mem_write) wr_seen = 1'b1;
      if (resp_valid) resp_cnt = resp_cnt + 1;
      @(negedge clk);
    end
    check("abort_no_write", {31'd0, wr_seen}, 32'd0);
    check("abort_no_resp", resp_cnt, 32'd0);
    run_req(mkv(1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_1255, 1'b0, 2, 1'b1, 1'b0, 32'h0));
    check("abort_word_unchanged", got_rdata, 32'hDEAD_1255);

    // Load then store queued with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0000_0008; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_write = 1'b1; req_addr = 32'h0000_000C; req_wdata = 32'h1122_3344;
    accept_cyc = 0; resp_cnt = 0; resp_first = 0; resp_second = 0; ready_busy = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        resp_cnt = resp_cnt + 1;
        if (resp_cnt == 1) resp_first = c;
        else resp_second = c;
      end
      if ((c <= 2) && req_ready) ready_busy = ready_busy + 1;
      if (req_valid && req_ready && (accept_cyc == 0)) begin
        accept_cyc = c;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_ready_busy", ready_busy, 32'd0);
    check("b2b_accept_cycle", accept_cyc, 32'd3);
    check("b2b_resp_count", resp_cnt, 32'd2);
    check("b2b_first_resp", resp_first, 32'd2);
    check("b2b_second_resp", resp_second, 32'd4);
    run_req(mkv(1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0, 32'h1122_3344, 1'b0, 2, 1'b1, 1'b0, 32'h0));
    check("b2b_store_readback", got_rdata, 32'h1122_3344);

    check("never_read_and_write", both_strobes, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
